dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single 16-bit data-memory port between the CPU core's load/store path and an external host/debug requester. It sits between the core's memory interface (we/addr/data_out/data_in) and the data memory. It issues at most one memory command per cycle under round-robin arbitration with an optional bounded host lock. It routes read data back to the originating requester and raises a stall to the CPU whenever the CPU's request is not granted.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4
- MAX_LOCK, 8, maximum consecutive host grants under host_lock while the CPU is requesting; legal range 1..255

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req / host_req  in  1  request valid
- cpu_we / host_we  in  1  1 = write, 0 = read
- cpu_addr / host_addr  in  ADDR_W  address
- cpu_wdata / host_wdata  in  DATA_W  write data
- host_lock  in  1  host requests consecutive grants (burst)
- cpu_gnt / host_gnt  out  1  combinational; request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid / host_rvalid  out  1  registered read-return strobe, one cycle
- cpu_rdata / host_rdata  out  DATA_W  registered read data; holds last value
- mem_en, mem_we  out  1  registered memory command
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data

## Operation
- Acceptance: a transfer is accepted in cycle k when req & gnt. Never both grants in one cycle. Grant requires req.
- Arbitration, with only one requester active: that requester is granted.
- Arbitration, with both active: the requester not granted most recently wins (last_gnt pointer), except as the lock rule below specifies. last_gnt updates only on acceptance.
- Lock: if host was accepted in cycle k with host_lock=1 and host_req=1, host_lock=1 in cycle k+1, the host wins ties in k+1. lock_cnt counts consecutive locked host acceptances while cpu_req=1.
- Lock limit: when lock_cnt reaches MAX_LOCK, the next tie goes to the CPU, and lock_cnt clears. lock_cnt also clears on any CPU acceptance or when host_lock=0.
- Command issue: on acceptance in cycle k, mem_en=1 in cycle k+1, with mem_we/addr/wdata copied from the winner. With no acceptance, mem_en=0 and mem_we=0. mem_addr/mem_wdata hold their previous values.
- Read return: a tag shift register of depth RD_LAT+1 carries {valid, owner}. mem_rdata is sampled at the end of cycle k+1+RD_LAT into the owner's rdata register. Owner rvalid=1 in cycle k+2+RD_LAT.
- Writes produce no rvalid.
- Ordering: commands reach memory in acceptance order. Back-to-back reads pipeline fully, one per cycle.
- A write followed by a read to the same address returns the new data, because memory order holds.
- Reset: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0, last_gnt=host (CPU wins the first tie), lock_cnt=0, all tags invalid.
- Reset mid-operation: in-flight reads are dropped, and no rvalid appears after rst deasserts for commands accepted before rst.

## Timing
- Grant: 0-cycle (combinational from req, last_gnt, lock state). No combinational path from mem_rdata to any output.
- Write: accepted in cycle k, memory write in cycle k+1.
- Read: accepted in cycle k, rvalid in cycle k+2+RD_LAT. RD_LAT=1 gives a 3-cycle latency.
- Throughput: one command per cycle, aggregate across both requesters.
- Simultaneous events: a new acceptance and a read return in the same cycle are independent.
- cpu_rvalid and host_rvalid may both be high only in separate cycles, because the command slots are unique.
- cpu_stall updates in the same cycle as cpu_req.

## Test plan
- Reset then idle: rst pulse, no requests -> all outputs 0 and mem_en stays 0 for 10 cycles.
- CPU alone: CPU write addr 0x0010 data 0xBEEF in cycle 2, then a read of 0x0010 in cycle 3 with RD_LAT=1 -> mem_en=1 in cycles 3 and 4; cpu_rvalid=1 in cycle 6 with cpu_rdata=0xBEEF; cpu_stall=0 throughout.
- Round-robin: both requesting reads every cycle for 6 cycles -> grants alternate CPU, host, CPU, ... starting with CPU. Each requester gets 3 rvalids in issue order, with no cycle gaps on mem_en.
- Host lock: host_lock=1, MAX_LOCK=3, both requesting continuously -> host granted 3 cycles, CPU granted 1, host 3, CPU 1; cpu_stall=1 exactly in the host-grant cycles.
- Latency sweep: RD_LAT=4, host read of 0x0022 (memory holds 0x1234) -> host_rvalid exactly 6 cycles after acceptance with host_rdata=0x1234; cpu_rvalid stays 0.
- Reset mid-flight: 2 CPU reads accepted, rst asserted 1 cycle later for 1 cycle -> no cpu_rvalid is ever produced. The first post-reset tie goes to the CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one data-memory port between the CPU and a host requester
//            (round-robin with bounded host lock) and routes read data back.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              cpu_gnt,
  output logic              host_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam logic [7:0] c_max_lock = 8'(MAX_LOCK);

  owner_t            r_last_gnt;
  logic              r_lock;
  logic [7:0]        r_lock_cnt;
  logic              w_host_wins_tie;
  logic              w_acc;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // Tag pipeline: bit i describes the read that reached memory i cycles ago.
  logic [RD_LAT:0]   r_tag_v;
  logic [RD_LAT:0]   r_tag_o;

  logic              r_cpu_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  // Tie-break: exhausted lock budget forces the CPU, an active lock favours
  // the host, otherwise whoever was not granted last.
  always_comb begin
    w_host_wins_tie = (r_last_gnt == OWN_CPU);
    if (r_lock_cnt >= c_max_lock) begin
      w_host_wins_tie = 1'b0;
    end else if (r_lock && host_lock) begin
      w_host_wins_tie = 1'b1;
    end
  end

  assign cpu_gnt     = cpu_req  & ~(host_req & w_host_wins_tie);
  assign host_gnt    = host_req & ~(cpu_req & ~w_host_wins_tie);
  assign cpu_stall   = cpu_req & ~cpu_gnt;

  assign w_acc       = cpu_gnt | host_gnt;
  assign w_win_we    = host_gnt ? host_we    : cpu_we;
  assign w_win_addr  = host_gnt ? host_addr  : cpu_addr;
  assign w_win_wdata = host_gnt ? host_wdata : cpu_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= OWN_HOST;
      r_lock     <= 1'b0;
      r_lock_cnt <= 8'd0;
    end else begin
      if (cpu_gnt) begin
        r_last_gnt <= OWN_CPU;
      end else if (host_gnt) begin
        r_last_gnt <= OWN_HOST;
      end
      r_lock <= host_gnt & host_lock;
      if (!host_lock || cpu_gnt) begin
        r_lock_cnt <= 8'd0;
      end else if (host_gnt && cpu_req && (r_lock_cnt < c_max_lock)) begin
        r_lock_cnt <= r_lock_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag_v     <= '0;
      r_tag_o     <= '0;
    end else begin
      r_mem_en <= w_acc;
      r_mem_we <= w_acc & w_win_we;
      if (w_acc) begin
        r_mem_addr  <= w_win_addr;
        r_mem_wdata <= w_win_wdata;
      end
      r_tag_v <= {r_tag_v[RD_LAT-1:0], w_acc & ~w_win_we};
      r_tag_o <= {r_tag_o[RD_LAT-1:0], host_gnt};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_cpu_rvalid  <= r_tag_v[RD_LAT] & ~r_tag_o[RD_LAT];
      r_host_rvalid <= r_tag_v[RD_LAT] &  r_tag_o[RD_LAT];
      if (r_tag_v[RD_LAT] && !r_tag_o[RD_LAT]) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (r_tag_v[RD_LAT] && r_tag_o[RD_LAT]) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign host_rvalid = r_host_rvalid;
  assign cpu_rdata   = r_cpu_rdata;
  assign host_rdata  = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed tables and sequences plus randomized
// traffic checked against a transaction-level model.
module tb_dmem_arbiter;
  localparam int LAT  = 1;
  localparam int MAXL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance under main test: RD_LAT=1, MAX_LOCK=3
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_gnt, host_gnt, cpu_stall, cpu_rvalid, host_rvalid;
  logic [15:0] cpu_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // Instance for the long-latency sweep: RD_LAT=4
  logic        cpu_req4, cpu_we4, host_req4, host_we4, host_lock4;
  logic [15:0] cpu_addr4, cpu_wdata4, host_addr4, host_wdata4;
  logic        cpu_gnt4, host_gnt4, cpu_stall4, cpu_rvalid4, host_rvalid4;
  logic [15:0] cpu_rdata4, host_rdata4;
  logic        mem_en4, mem_we4;
  logic [15:0] mem_addr4, mem_wdata4, mem_rdata4;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT), .MAX_LOCK(MAXL)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .cpu_gnt(cpu_gnt), .host_gnt(host_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(4), .MAX_LOCK(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req4), .cpu_we(cpu_we4), .cpu_addr(cpu_addr4), .cpu_wdata(cpu_wdata4),
    .host_req(host_req4), .host_we(host_we4), .host_addr(host_addr4), .host_wdata(host_wdata4),
    .host_lock(host_lock4), .cpu_gnt(cpu_gnt4), .host_gnt(host_gnt4), .cpu_stall(cpu_stall4),
    .cpu_rvalid(cpu_rvalid4), .cpu_rdata(cpu_rdata4), .host_rvalid(host_rvalid4), .host_rdata(host_rdata4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  // Background memory contents for locations never written
  function automatic logic [15:0] init_val(input logic [11:0] a);
    return {4'h0, a} ^ 16'hA5A5;
  endfunction

  // Memory behind u_dut: one-cycle registered read
  logic [15:0] env_mem [0:4095];
  bit          env_wr  [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr[11:0]] <= mem_wdata;
        env_wr[mem_addr[11:0]]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr[11:0]] ? env_mem[mem_addr[11:0]] : init_val(mem_addr[11:0]);
      end
    end
  end

  // Memory behind u_dut4: read-only, four-cycle read pipeline
  logic [15:0] p0, p1, p2;
  always @(posedge clk) begin
    if (mem_en4 && !mem_we4) begin
      p0 <= (mem_addr4 == 16'h0022) ? 16'h1234 : init_val(mem_addr4[11:0]);
    end
    p1         <= p0;
    p2         <= p1;
    mem_rdata4 <= p2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic h, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
                       input logic hl);
    cpu_req = c;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
    host_req = h; host_we = hw; host_addr = ha; host_wdata = hd;
    host_lock = hl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic c, h, l;
    logic gc, gh, st;
  } vec_t;
  vec_t vecs [0:12];

  typedef struct {
    int          due;
    logic        host;
    logic [15:0] data;
  } ret_t;
  ret_t rq[$];

  logic [15:0] cpu_got[$];
  logic [15:0] host_got[$];

  logic        m_last_host, m_prev_locked;
  int          m_streak;
  logic [15:0] mmem [0:7];
  logic        e_en, e_we;
  logic [15:0] e_addr, e_wd, e_crd, e_hrd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Arbitration table, applied from reset: last_gnt=host, MAX_LOCK=3
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    cpu_req4 = 1'b0; cpu_we4 = 1'b0; cpu_addr4 = 16'h0; cpu_wdata4 = 16'h0;
    host_req4 = 1'b0; host_we4 = 1'b0; host_addr4 = 16'h0; host_wdata4 = 16'h0;
    host_lock4 = 1'b0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ctl", {mem_en, mem_we, cpu_rvalid, host_rvalid, cpu_gnt, host_gnt, cpu_stall}, 0);
      chk("idle_data", {mem_addr, mem_wdata, cpu_rdata, host_rdata}, 0);
      @(negedge clk);
    end

    // CPU alone: write then read back the same address
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1 chk("cpu_wr_gnt", {cpu_gnt, cpu_stall}, 2'b10);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1 chk("cpu_rd_gnt", {cpu_gnt, cpu_stall}, 2'b10);
    chk("cpu_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0010, 16'hBEEF});
    @(negedge clk);
    idle();
    #1 chk("cpu_rd_cmd", {mem_en, mem_we, mem_addr, cpu_rvalid, cpu_stall}, {2'b10, 16'h0010, 2'b00});
    @(negedge clk);
    #1 chk("cpu_rd_wait", {mem_en, cpu_rvalid}, 2'b00);
    @(negedge clk);
    #1 chk("cpu_rd_ret", {cpu_rvalid, host_rvalid, cpu_rdata}, {2'b10, 16'hBEEF});
    @(negedge clk);
    #1 chk("cpu_rd_hold", {cpu_rvalid, cpu_rdata}, {1'b0, 16'hBEEF});
    @(negedge clk);

    // Round-robin with both reading every cycle
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        drive(1'b1, 1'b0, 16'h0020 + 16'(i / 2), 16'h0, 1'b1, 1'b0, 16'h0030 + 16'(i / 2), 16'h0, 1'b0);
      end else begin
        idle();
      end
      #1;
      if (i < 6) chk("rr_gnt", {cpu_gnt, host_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i >= 1 && i <= 6) chk("rr_mem_en", mem_en, 1'b1);
      chk("rr_rv_excl", cpu_rvalid & host_rvalid, 1'b0);
      if (cpu_rvalid) cpu_got.push_back(cpu_rdata);
      if (host_rvalid) host_got.push_back(host_rdata);
      @(negedge clk);
    end
    chk("rr_cpu_cnt", cpu_got.size(), 3);
    chk("rr_host_cnt", host_got.size(), 3);
    for (int k = 0; k < 3 && k < cpu_got.size(); k++) chk("rr_cpu_data", cpu_got[k], init_val(12'h020 + 12'(k)));
    for (int k = 0; k < 3 && k < host_got.size(); k++) chk("rr_host_data", host_got[k], init_val(12'h030 + 12'(k)));

    // Arbitration / host-lock table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].c, 1'b1, 16'h0050, 16'(i), vecs[i].h, 1'b1, 16'h0050, 16'(i), vecs[i].l);
      #1;
      chk("vec_gnt", {cpu_gnt, host_gnt, cpu_stall}, {vecs[i].gc, vecs[i].gh, vecs[i].st});
      @(negedge clk);
    end
    idle();

    // Latency sweep on the RD_LAT=4 instance
    host_req4 = 1'b1; host_addr4 = 16'h0022;
    #1 chk("lat4_gnt", {cpu_gnt4, host_gnt4, cpu_stall4}, 3'b010);
    @(negedge clk);
    host_req4 = 1'b0;
    for (int d = 1; d <= 8; d++) begin
      #1;
      if (d == 1) chk("lat4_cmd", {mem_en4, mem_we4, mem_addr4, mem_wdata4}, {2'b10, 16'h0022, 16'h0});
      chk("lat4_rv", {host_rvalid4, cpu_rvalid4}, {(d == 6), 1'b0});
      if (d == 6) chk("lat4_data", host_rdata4, 16'h1234);
      chk("lat4_cpu_rd", cpu_rdata4, 16'h0);
      @(negedge clk);
    end

    // Reset while two CPU reads are in flight
    do_reset();
    drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1 chk("mid_gnt0", cpu_gnt, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0041, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1 chk("mid_gnt1", cpu_gnt, 1'b1);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1 chk("mid_rst_mem", {mem_en, cpu_rvalid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("mid_no_rv", {cpu_rvalid, host_rvalid}, 2'b00);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0, 1'b0);
    #1 chk("mid_first_tie", {cpu_gnt, host_gnt, cpu_stall}, 3'b100);
    @(negedge clk);

    // Randomized traffic against a transaction-level model
    do_reset();
    m_last_host = 1'b1; m_prev_locked = 1'b0; m_streak = 0;
    rq.delete();
    e_en = 1'b0; e_we = 1'b0; e_addr = 16'h0; e_wd = 16'h0; e_crd = 16'h0; e_hrd = 16'h0;
    for (int a = 0; a < 8; a++) mmem[a] = init_val(12'h100 + 12'(a));
    for (int t = 0; t < 410; t++) begin
      logic cr, hr, hl, cw, hw, hwin, ac, ah, xcv, xhv;
      logic [15:0] ca, ha, cd, hd;
      cr = (t < 400) && ($urandom_range(0, 3) != 0);
      hr = (t < 400) && ($urandom_range(0, 4) > 1);
      hl = ($urandom_range(0, 3) != 0);
      cw = $urandom_range(0, 2) == 0;
      hw = $urandom_range(0, 2) == 0;
      ca = 16'h0100 + 16'($urandom_range(0, 7));
      ha = 16'h0100 + 16'($urandom_range(0, 7));
      cd = 16'($urandom);
      hd = 16'($urandom);
      drive(cr, cw, ca, cd, hr, hw, ha, hd, hl);
      #1;
      // Winner from the arbitration rules
      hwin = 1'b0;
      if (cr && hr) begin
        if (m_streak >= MAXL) hwin = 1'b0;
        else if (m_prev_locked && hl) hwin = 1'b1;
        else hwin = !m_last_host;
      end
      ac = cr && !(hr && hwin);
      ah = hr && !(cr && !hwin);
      xcv = 1'b0;
      xhv = 1'b0;
      if (rq.size() > 0 && rq[0].due == t) begin
        if (rq[0].host) begin xhv = 1'b1; e_hrd = rq[0].data; end
        else begin xcv = 1'b1; e_crd = rq[0].data; end
        void'(rq.pop_front());
      end
      chk("rnd_cpu_gnt", cpu_gnt, ac);
      chk("rnd_host_gnt", host_gnt, ah);
      chk("rnd_stall", cpu_stall, cr && !ac);
      chk("rnd_mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {e_en, e_we, e_addr, e_wd});
      chk("rnd_rvalid", {cpu_rvalid, host_rvalid}, {xcv, xhv});
      chk("rnd_rdata", {cpu_rdata, host_rdata}, {e_crd, e_hrd});
      if (ac || ah) begin
        e_en   = 1'b1;
        e_we   = ah ? hw : cw;
        e_addr = ah ? ha : ca;
        e_wd   = ah ? hd : cd;
        if (e_we) mmem[e_addr[2:0]] = e_wd;
        else rq.push_back('{due: t + 2 + LAT, host: ah, data: mmem[e_addr[2:0]]});
        m_last_host = ah;
      end else begin
        e_en = 1'b0;
        e_we = 1'b0;
      end
      if (!hl || ac) m_streak = 0;
      else if (ah && cr) m_streak++;
      m_prev_locked = ah && hl;
      @(negedge clk);
    end
    chk("rnd_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
